// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle sequencer driving a 4-bit combinational ALU slice one nibble per cycle.
// Optional out_zero result flag is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_result,
  output logic                   out_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                   out_zero,
`endif
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [2:0]             alu_sel,
  input  logic [3:0]             alu_result,
  input  logic                   alu_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_NOT = 3'b101, OP_SHL = 3'b110, OP_SHR = 3'b111
  } op_t;

  state_t          state_q;
  op_t             op_q;
  logic [W-1:0]    a_q, b_q, res_q, res_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_cout_q;
  logic [W-1:0]    out_result_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic            out_zero_q;
`endif

  logic            accept, arith, is_last, run;
  logic [3:0]      a_nib, b_nib, nib_cap;

  always_comb begin
    run      = (state_q == S_RUN);
    arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready;
    is_last  = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == LAST);

    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end

    // Shifts carry the bit leaving the neighbouring nibble into the vacated end.
    nib_cap = alu_result;
    if (op_q == OP_SHL) nib_cap[0] = alu_result[0] | carry_q;
    if (op_q == OP_SHR) nib_cap[3] = alu_result[3] | carry_q;

    res_d = res_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) res_d[4*i +: 4] = nib_cap;
    end

    carry_d = (arith || (op_q == OP_SHL) || (op_q == OP_SHR)) ? alu_cout : 1'b0;

    alu_a   = run ? a_nib : '0;
    alu_b   = run ? b_nib : '0;
    alu_cin = run && arith ? carry_q : 1'b0;
    alu_sel = op_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      out_zero_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          idx_q   <= (op_q == OP_SHR) ? idx_q - IW'(1) : idx_q + IW'(1);
          if (is_last) begin
            out_result_q <= res_d;
            out_cout_q   <= carry_d;
            out_valid_q  <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            out_zero_q   <= (res_d == '0);
`endif
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Accept overrides the DONE->IDLE move so a waiting command starts with no bubble.
      if (accept) begin
        op_q    <= op_t'(in_op);
        a_q     <= in_a;
        b_q     <= in_b;
        res_q   <= '0;
        idx_q   <= (op_t'(in_op) == OP_SHR) ? LAST : '0;
        carry_q <= ((op_t'(in_op) == OP_ADD) || (op_t'(in_op) == OP_SUB)) ? in_cin : 1'b0;
        state_q <= S_RUN;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign out_zero   = out_zero_q;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice
// and a scoreboard of whole-word expected results.
module tb_alu_nibble_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout;
  logic [W-1:0] out_result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         out_zero;
`endif
  logic [3:0]   alu_a, alu_b, alu_result;
  logic         alu_cin, alu_cout;
  logic [2:0]   alu_sel;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .out_zero(out_zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-bit combinational ALU slice
  logic [4:0] t5;
  always_comb begin
    t5 = '0;
    alu_result = '0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'd0: begin t5 = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin); alu_result = t5[3:0]; alu_cout = t5[4]; end
      3'd1: begin t5 = {1'b0, alu_a} - {1'b0, alu_b} - 5'(alu_cin); alu_result = t5[3:0]; alu_cout = t5[4]; end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: begin alu_result = {alu_a[2:0], 1'b0}; alu_cout = alu_a[3]; end
      default: begin alu_result = {1'b0, alu_a[3:1]}; alu_cout = alu_a[0]; end
    endcase
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b, input logic cin);
    exp_t x;
    logic [W:0] t;
    x.acc = 0;
    x.cout = 1'b0;
    x.res = '0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b} + (W+1)'(cin); x.res = t[W-1:0]; x.cout = t[W]; end
      3'd1: begin x.res = a - b - W'(cin); x.cout = ({1'b0, a} < ({1'b0, b} + (W+1)'(cin))); end
      3'd2: x.res = a & b;
      3'd3: x.res = a | b;
      3'd4: x.res = a ^ b;
      3'd5: x.res = ~a;
      3'd6: begin x.res = a << 1; x.cout = a[W-1]; end
      default: begin x.res = a >> 1; x.cout = a[0]; end
    endcase
    x.zero = (x.res == '0);
    return x;
  endfunction

  // Output side of the scoreboard: latency on each rise, values on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid && sb.size() != 0) begin
        checks++;
        if (cyc - sb[0].acc !== N) begin
          errors++;
          $display("FAIL latency: got %0d cycles, want %0d", cyc - sb[0].acc, N);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %h with no command pending", out_result);
        end else begin
          e = sb.pop_front();
          checks++;
          if (out_result !== e.res) begin
            errors++;
            $display("FAIL result: got %h want %h", out_result, e.res);
          end
          checks++;
          if (out_cout !== e.cout) begin
            errors++;
            $display("FAIL cout: got %b want %b (result %h)", out_cout, e.cout, e.res);
          end
`ifdef ALU_SEQ_ZERO_FLAG_EN
          checks++;
          if (out_zero !== e.zero) begin
            errors++;
            $display("FAIL zero: got %b want %b (result %h)", out_zero, e.zero, e.res);
          end
`endif
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, b, input logic cin, input bit track);
    exp_t x;
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin;
    @(negedge clk);
    while (!in_ready && n < 30) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end else if (track) begin
      x = model(op, a, b, cin);
      x.acc = cyc + 1;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin n++; @(negedge clk); end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
    checks++; if ({alu_a, alu_b, alu_cin} !== 9'd0) begin errors++; $display("FAIL reset_alu_ports: got %h want 0", {alu_a, alu_b, alu_cin}); end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1);
    send(3'd0, 16'h1234, 16'h0FCD, 1'b1, 1);
    wait_drain();
  endtask

  task automatic test_sub();
    send(3'd1, 16'h1000, 16'h0001, 1'b0, 1);
    send(3'd1, 16'h0000, 16'h0001, 1'b0, 1);
    send(3'd1, 16'h0005, 16'h0003, 1'b1, 1);
    wait_drain();
  endtask

  task automatic test_shift();
    logic [15:0] seq;
    seq = 16'h8421;
    send(3'd6, 16'h8421, 16'h0000, 1'b0, 1);
    wait_drain();
    send(3'd7, 16'h8421, 16'h0000, 1'b0, 1);
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      checks++;
      if (alu_a !== seq[4*k +: 4]) begin
        errors++;
        $display("FAIL shr_alu_a_seq: step %0d got %h want %h", 3 - k, alu_a, seq[4*k +: 4]);
      end
    end
    wait_drain();
  endtask

  task automatic test_logic();
    send(3'd5, 16'h00F0, 16'h1234, 1'b1, 1);
    send(3'd4, 16'hAAAA, 16'h5555, 1'b0, 1);
    send(3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int c0;
    out_ready = 1'b0;
    send(3'd0, 16'h1234, 16'h4321, 1'b0, 1);
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, in_ready, out_cout, out_result} !== {1'b1, 1'b0, 1'b0, 16'h5555}) begin
        errors++;
        $display("FAIL bp_hold: valid=%b ready=%b cout=%b result=%h want 1 0 0 5555",
                 out_valid, in_ready, out_cout, out_result);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    c0 = cyc;
    send(3'd3, 16'h0F00, 16'h00F0, 1'b0, 1);
    checks++;
    if (sb.size() == 0 || sb[$].acc !== c0 + 1) begin
      errors++;
      $display("FAIL same_cycle_accept: accept cycle %0d want %0d", (sb.size() == 0) ? -1 : sb[$].acc, c0 + 1);
    end
    send(3'd0, 16'h0001, 16'h0001, 1'b0, 1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    send(3'd0, 16'h1234, 16'h1111, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    checks++; if ({alu_a, alu_b} !== 8'h00) begin errors++; $display("FAIL midrst_alu_ab: got %h want 00", {alu_a, alu_b}); end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_no_result: out_valid seen=1 want 0"); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover: pending %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle operation sequencer placed directly upstream of the 4-bit combinational ALU slice. It accepts a wide operation (op code, two operands, carry-in) on a valid/ready handshake. It then drives the ALU slice one nibble per cycle, chaining carry, borrow and shift bits between passes, and assembles the wide result. The assembled result is presented to the downstream consumer on a second valid/ready handshake.

## Interface
- NIBBLES, default 4: number of 4-bit passes. Operand width W = 4*NIBBLES. Legal range is 2..8.
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command valid
- in_ready  out  1  sequencer can accept a command
- in_op  in  3  op code, same encoding as the ALU slice: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not-a, 110 shl, 111 shr
- in_a, in_b  in  W  operands
- in_cin  in  1  carry/borrow-in; add/sub only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  W  assembled result
- out_cout  out  1  final carry/borrow/shifted-out bit
- alu_a, alu_b  out  4  nibble operands to the ALU slice
- alu_cin  out  1  chained carry to the ALU slice
- alu_sel  out  3  op to the ALU slice
- alu_result  in  4  ALU slice result
- alu_cout  in  1  ALU slice carry-out

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **in_ready** = (state==IDLE) | (state==DONE & out_ready). A command is accepted on the edge where in_valid & in_ready.
- **On accept**
  - Latch op, a, b into registers.
  - Clear the result register.
  - Nibble index idx = NIBBLES-1 for shr, otherwise 0.
  - Carry register = in_cin for add/sub, otherwise 0.
  - Go to RUN.
- **RUN, ALU drive (combinational)**
  - alu_a = a[idx], alu_b = b[idx], alu_sel = op.
  - alu_cin = carry for add/sub, otherwise 0.
- **RUN, capture on each edge**
  - result[idx] = alu_result.
  - For shl, result[idx] additionally has bit0 |= carry.
  - For shr, result[idx] additionally has bit3 |= carry.
  - carry = alu_cout for add/sub/shl/shr; for logic ops carry stays 0.
  - idx steps +1, or -1 for shr.
- **Sub chaining:** the ALU slice's cout is the borrow; it is chained as cin for the next nibble.
- **Last nibble** (idx==NIBBLES-1, or 0 for shr):
  - out_result is loaded from the result register including this nibble.
  - out_cout = final carry.
  - out_valid = 1, state goes to DONE.
- **DONE:** hold out_result, out_cout and out_valid until out_ready.
  - On out_ready with a new accept: go directly to RUN.
  - On out_ready with no accept: go to IDLE and clear out_valid.
- **ALU ports outside RUN:** alu_a = alu_b = 0, alu_cin = 0, alu_sel = latched op.
- **Width rules:** arithmetic is modulo 2^W.
  - add: cout = carry out of bit W-1.
  - sub: cout = 1 iff a < b + cin.
  - shl: cout = a[W-1]. shr: cout = a[0].
  - logic ops and not: cout = 0.
- **Reset values:** state IDLE, out_valid 0, out_result 0, out_cout 0, idx 0, carry 0. in_ready reads 1 in the first cycle after reset is released.
- **Reset during RUN or DONE:** the operation is discarded and no out_valid is produced.
- The command on in_* is ignored whenever in_ready is 0; it is not queued.

## Timing
- Accept at edge T. RUN occupies cycles T+1..T+NIBBLES. out_valid rises at edge T+NIBBLES, i.e. latency is NIBBLES cycles from accept to out_valid.
- Back-to-back throughput is one command per NIBBLES+1 cycles, with zero bubble when out_ready is held high.
- The ALU slice is purely combinational: alu_result must settle within the same cycle as alu_a/alu_b. There is no registered ALU path.
- out_result and out_cout are stable for the whole time out_valid=1 and out_ready=0.

## Configuration
- **ALU_SEQ_ZERO_FLAG_EN**
  - Defined: adds output port out_zero (1 bit). It is registered at the same edge as out_result and equals (result == 0) for every op, independent of cout. It resets to 0 and is held in DONE.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- **ADD with carry-out** (NIBBLES=4): add 0xFFFF+0x0001, cin=0 → out_result 0x0000, out_cout 1, out_valid exactly 4 cycles after accept; out_zero 1 if enabled.
- **SUB with borrow:** 0x1000-0x0001, cin=0 → 0x0FFF, cout 0. Then 0x0000-0x0001 → 0xFFFF, cout 1. Then 0x0005-0x0003, cin=1 → 0x0001, cout 0.
- **Shift chaining:** shl 0x8421 → 0x0842, cout 1. shr 0x8421 → 0x4210, cout 1; alu_a sequence on successive RUN cycles must be 8,4,2,1.
- **Logic ops:** not 0x00F0 → 0xFF0F, cout 0. xor 0xAAAA^0x5555 → 0xFFFF, cout 0.
- **Backpressure and back-to-back:**
  - Hold out_ready=0 for 3 cycles: result and out_valid are unchanged and in_ready=0 throughout.
  - Then raise out_ready with in_valid=1: the next command is accepted in the same cycle, and its result appears 4 cycles later.
- **Reset mid-operation:** assert rst after 2 RUN cycles → the next cycle shows out_valid 0, in_ready 1 and alu_a/alu_b 0; the aborted command never produces a result.
